// File: rtl/mem_stage_mc_if.sv
// Request/acknowledge bus between the memory-stage controller and a multicycle memory.
// The controller drives the request side (master); the memory answers on the slave side.
interface mem_stage_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Memory-stage controller: issues one load/store per instruction to a multicycle memory,
// stalls the pipeline until ack or timeout, and flags misaligned/illegal accesses.
module mem_stage_mc #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              createdump,
  output logic [DATA_W-1:0] read_data_out,
  output logic              Stall,
  output logic              Done,
  output logic              err,
  output logic              mem_dump,
  mem_stage_mc_if.master    mem
);

  localparam int LSB_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic op_valid;
  logic misaligned;
  logic illegal;
  logic accept;

  assign op_valid   = MemRead | MemWrite;
  assign misaligned = |ALU_result[LSB_W-1:0];
  assign illegal    = MemRead & MemWrite;
  assign accept     = (state == S_IDLE) & op_valid & ~misaligned & ~illegal;

  // Stall must rise in the accept cycle itself, so it cannot wait for a registered state.
  assign Stall    = accept | (state == S_WAIT);
  assign err      = ((state == S_IDLE) & op_valid & (misaligned | illegal)) |
                    ((state == S_DONE) & err_q);
  assign mem_dump = createdump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      err_q         <= 1'b0;
      Done          <= 1'b0;
      read_data_out <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mem.mem_addr  <= ALU_result;
            mem.mem_wdata <= write_data;
            mem.mem_wr    <= MemWrite;
            mem.mem_req   <= 1'b1;
            cnt           <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // An ack arriving on the last allowed cycle still counts as a success.
          if (mem.mem_ack) begin
            if (!mem.mem_wr) read_data_out <= mem.mem_rdata;
            err_q       <= 1'b0;
            mem.mem_req <= 1'b0;
            Done        <= 1'b1;
            state       <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err_q         <= 1'b1;
            read_data_out <= '0;
            mem.mem_req   <= 1'b0;
            Done          <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: directed test-plan steps followed by randomized
// accesses, all checked against a word-addressed memory model kept in the bench.
module tb_mem_stage_mc;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ALU_result;
  logic [DATA_W-1:0] write_data;
  logic              MemRead;
  logic              MemWrite;
  logic              createdump;
  logic [DATA_W-1:0] read_data_out;
  logic              Stall;
  logic              Done;
  logic              err;
  logic              mem_dump;

  mem_stage_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  mem_stage_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ALU_result    (ALU_result),
    .write_data    (write_data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .createdump    (createdump),
    .read_data_out (read_data_out),
    .Stall         (Stall),
    .Done          (Done),
    .err           (err),
    .mem_dump      (mem_dump),
    .mem           (mem_bus.master)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: memory contents and the load result the pipeline should currently see.
  logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] exp_rd = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input bit dump);
    MemRead    = rd;
    MemWrite   = wr;
    ALU_result = addr;
    write_data = wdata;
    createdump = dump;
  endtask

  // One legal access; ack_at is the WAIT cycle (1-based) carrying the ack, outside 1..TIMEOUT means none.
  task automatic doAccess(input bit rd, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int ack_at);
    bit acked = 1'b0;
    int stall_count = 0;
    applyStimulus(rd, !rd, addr, wdata, 1'($urandom_range(0, 1)));
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    if (Stall) stall_count++;
    checkOutput("accept_req", mem_bus.mem_req, 0);
    checkOutput("accept_err", err, 0);
    checkOutput("accept_done", Done, 0);
    checkOutput("mem_dump", mem_dump, createdump);
    @(posedge clk); #1;
    for (int w = 1; w <= TIMEOUT && !acked; w++) begin
      if (w == ack_at) begin
        acked = 1'b1;
        mem_bus.mem_ack = 1'b1;
        if (rd && !mem_model.exists(addr)) mem_model[addr] = DATA_W'($urandom);
        mem_bus.mem_rdata = rd ? mem_model[addr] : DATA_W'($urandom);
      end else begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = DATA_W'($urandom);
      end
      @(negedge clk);
      if (Stall) stall_count++;
      checkOutput("wait_req", mem_bus.mem_req, 1);
      checkOutput("wait_done", Done, 0);
      checkOutput("wait_addr", mem_bus.mem_addr, addr);
      checkOutput("wait_wr", mem_bus.mem_wr, !rd);
      if (!rd) checkOutput("wait_wdata", mem_bus.mem_wdata, wdata);
      @(posedge clk); #1;
    end
    mem_bus.mem_ack = 1'b0;
    if (acked && !rd) mem_model[addr] = wdata;
    if (acked && rd) exp_rd = mem_model[addr];
    if (!acked) exp_rd = '0;
    @(negedge clk);
    checkOutput("stall_cycles", stall_count, acked ? ack_at + 1 : TIMEOUT + 1);
    checkOutput("done_pulse", Done, 1);
    checkOutput("done_stall", Stall, 0);
    checkOutput("done_req", mem_bus.mem_req, 0);
    checkOutput("done_err", err, !acked);
    checkOutput("done_rdata", read_data_out, exp_rd);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Misaligned or illegal request: rejected in the same cycle, nothing reaches memory.
  task automatic doBad(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr);
    applyStimulus(rd, wr, addr, DATA_W'($urandom), 1'b0);
    mem_bus.mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("bad_err", err, 1);
    checkOutput("bad_stall", Stall, 0);
    checkOutput("bad_req", mem_bus.mem_req, 0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("bad_after_req", mem_bus.mem_req, 0);
    checkOutput("bad_after_done", Done, 0);
    checkOutput("bad_after_rdata", read_data_out, exp_rd);
    @(posedge clk); #1;
  endtask

  // Load aborted by reset in WAIT cycle rst_at; the ack comes later or together with reset.
  task automatic doResetAccess(input logic [ADDR_W-1:0] addr, input int rst_at, input bit ack_with_rst);
    applyStimulus(1'b1, 1'b0, addr, '0, 1'b0);
    mem_bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    for (int w = 1; w <= rst_at; w++) begin
      rst = (w == rst_at);
      mem_bus.mem_ack   = (w == rst_at) && ack_with_rst;
      mem_bus.mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      checkOutput("rstacc_req", mem_bus.mem_req, 1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = DATA_W'($urandom);
    exp_rd = '0;
    @(negedge clk);
    checkOutput("rstacc_req_off", mem_bus.mem_req, 0);
    checkOutput("rstacc_done", Done, 0);
    checkOutput("rstacc_stall", Stall, 0);
    checkOutput("rstacc_rdata", read_data_out, exp_rd);
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("rstacc_done_late", Done, 0);
    checkOutput("rstacc_req_late", mem_bus.mem_req, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the stimulus finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rdata", read_data_out, 0);
    checkOutput("reset_req", mem_bus.mem_req, 0);
    checkOutput("reset_wr", mem_bus.mem_wr, 0);
    checkOutput("reset_addr", mem_bus.mem_addr, 0);
    checkOutput("reset_wdata", mem_bus.mem_wdata, 0);
    checkOutput("reset_done", Done, 0);
    checkOutput("reset_stall", Stall, 0);
    checkOutput("reset_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed test-plan steps");
    mem_model[16'h0010] = 16'hBEEF;
    doAccess(1'b1, 16'h0010, '0, 3);
    doAccess(1'b0, 16'h0020, 16'h1234, 2);
    doAccess(1'b1, 16'h0020, '0, 1);
    doBad(1'b1, 1'b0, 16'h0011);
    doBad(1'b1, 1'b1, 16'h0030);
    doAccess(1'b1, 16'h0040, '0, 0);
    doAccess(1'b1, 16'h0010, '0, TIMEOUT);
    doResetAccess(16'h0010, 2, 1'b0);
    doAccess(1'b1, 16'h0020, '0, 1);
    doResetAccess(16'h0020, 3, 1'b1);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        if ($urandom_range(0, 1) == 1)
          doBad(1'b1, 1'b0, ADDR_W'($urandom) | ADDR_W'(1));
        else
          doBad(1'b1, 1'b1, ADDR_W'(16'h0100 + 2 * $urandom_range(0, 15)));
      end else if (kind == 1) begin
        doResetAccess(ADDR_W'(16'h0100 + 2 * $urandom_range(0, 15)),
                      int'($urandom_range(1, TIMEOUT - 1)), 1'($urandom_range(0, 1)));
      end else begin
        doAccess(1'($urandom_range(0, 1)), ADDR_W'(16'h0100 + 2 * $urandom_range(0, 15)),
                 DATA_W'($urandom), int'($urandom_range(0, TIMEOUT + 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parametrised Memory-stage controller for a multicycle backing memory (cache or banked memory) behind a request/acknowledge interface. Accepts one load or store per instruction from the Execute/Memory pipeline register and issues it to memory. Holds the pipeline with `Stall` until memory acknowledges, then returns load data and pulses `Done`. Adds alignment checking, illegal-op detection and a no-response timeout.

## Interface
- `DATA_W`, default 16: data width in bits; a multiple of 8, at least 16.
- `ADDR_W`, default 16: address width in bits.
- `TIMEOUT`, default 64: maximum cycles in WAIT before the access is aborted; at least 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ALU_result` in ADDR_W: byte address of the access.
- `write_data` in DATA_W: store data.
- `MemRead` in 1: load request; level, held by the pipeline while stalled.
- `MemWrite` in 1: store request; level, held by the pipeline while stalled.
- `createdump` in 1: dump request from the halt logic.
- `read_data_out` out DATA_W: data from the last completed load.
- `Stall` out 1: freeze the pipeline this cycle.
- `Done` out 1: access completed this cycle.
- `err` out 1: error indication.
- `mem_req` out 1: memory request.
- `mem_wr` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data; valid with `mem_ack`.
- `mem_ack` in 1: memory completion, one-cycle pulse.
- `mem_dump` out 1: equals `createdump` (combinational).

## Operation
- `op_valid` = `MemRead` | `MemWrite`.
- Misaligned access: any of the low log2(DATA_W/8) bits of `ALU_result` is 1.
- Illegal access: `MemRead` & `MemWrite`.
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - `op_valid` and not misaligned/illegal: latch `ALU_result`, `write_data` and `MemWrite` into `mem_addr`, `mem_wdata` and `mem_wr`; clear the timeout counter; go to WAIT.
  - `op_valid` and misaligned or illegal: no memory request; stay in IDLE; `err` = 1 combinationally this cycle; `Stall` = 0.
  - `mem_ack` is ignored in IDLE.
- **WAIT**
  - `mem_req` = 1; `mem_addr`, `mem_wdata` and `mem_wr` are held stable.
  - Timeout counter increments each cycle.
  - `mem_ack` = 1: if the access is a read, `read_data_out` <= `mem_rdata`; go to DONE, `err_q` = 0.
  - No ack and counter = TIMEOUT-1: go to DONE, `err_q` = 1, `read_data_out` <= 0; `mem_req` drops.
- **DONE**
  - `Done` = 1, `Stall` = 0, `err` = `err_q`.
  - Always returns to IDLE; never reissues, because the pipeline inputs still hold the same instruction during this cycle.
- `Stall` = (IDLE & `op_valid` & aligned & legal) | WAIT. Combinational, so the pipeline freezes in the accept cycle itself.
- `read_data_out` holds its value between loads; stores and aborted-read-only cases follow the rules above.

## Timing
- Reset values: state IDLE; `read_data_out`, `mem_addr`, `mem_wdata`, `err_q`, counter = 0; `mem_req`, `mem_wr`, `Done` = 0.
- Latency: request accepted in cycle T. `mem_req` is high from T+1. An ack in cycle T+k (k ≥ 1) gives `Done` in T+k+1, and the pipeline advances at the end of T+k+1. Minimum total is 3 cycles per access.
- An ack in the first WAIT cycle is legal.
- `mem_req` is deasserted on the edge after the ack, so at most one ack is consumed per request.
- Back-to-back accesses: the next instruction is presented in the cycle after DONE and accepted in IDLE. The accepted-to-accepted rate is one access every k+2 cycles.
- `rst` in WAIT: returns to IDLE next edge with `mem_req` = 0; a late ack is ignored. `rst` wins over `mem_ack` in the same cycle.
- `rst` in DONE: no `Done` pulse on the following cycle.
- The timeout counter is ceil(log2(TIMEOUT))+1 bits and saturates, never wrapping.

## Test plan
- **Load:** address 0x0010 with `MemRead`. Memory acks 3 cycles after `mem_req` with 0xBEEF. Expect `Stall` for 4 cycles, then `Done` for 1 cycle, `read_data_out` = 0xBEEF, `err` = 0.
- **Store then load:** store 0x1234 to 0x0020; expect `mem_wr` = 1 and `mem_wdata` = 0x1234 stable until ack, and `read_data_out` unchanged. Then load 0x0020 with an immediate ack; expect 3-cycle completion.
- **Misaligned:** `MemRead` at 0x0011. Expect `err` = 1 in the same cycle, `Stall` = 0, `mem_req` never asserted.
- **Illegal op:** `MemRead` and `MemWrite` both high. Same response as the misaligned case.
- **Timeout:** TIMEOUT = 8, no ack. Expect `mem_req` high for 8 cycles, then `Done` = 1, `err` = 1, `read_data_out` = 0.
- **Reset mid-access:** assert `rst` in the second WAIT cycle, then ack one cycle later. Expect IDLE, `mem_req` = 0, no `Done`, `read_data_out` = 0.
